trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 161 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: interrupt entry / mret return controller for the multicycle core.
// It sits between the instruction-boundary pulse from the core FSM and the
// CSR file / fetch unit. At each boundary it either redirects fetch to mtvec
// (interrupt entry), redirects fetch to mepc (mret), or lets the core keep
// running. After a redirect it holds fetch for one extra SETTLE cycle so the
// CSR update is visible before the next instruction starts.
//
// Optional feature: define TRAP_CTRL_IRQ_SYNC_EN to pass the asynchronous irq
// input through a two-flop synchronizer. This adds two cycles of irq latency.
// Without the macro, irq is assumed to already be synchronous to clk.

module trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        irq,
   input  logic        instr_done,
   input  logic        is_mret,
   input  logic        mie,
   input  logic        mstatus,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        int_taken,
   output logic        int_ret,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        hold,
   output logic        irq_pending,
   output logic [15:0] int_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      TAKE   = 2'd1,
      RET    = 2'd2,
      SETTLE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic        irq_s;
   logic        irq_d;
   logic        irq_edge;
   logic [15:0] count_q;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
   logic        sync_1;
   logic        sync_2;

   // Two-flop synchronizer bringing the asynchronous irq into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= irq;
         sync_2 <= sync_1;
      end
   end

   assign irq_s = sync_2;
`else
   assign irq_s = irq;
`endif

   // Delayed copy of the synchronized irq, used to detect a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_d <= 1'b0;
      end else begin
         irq_d <= irq_s;
      end
   end

   assign irq_edge = irq_s & ~irq_d;

   // Pending latch: a rising edge sets it, service in TAKE clears it, and a
   // new edge arriving in the same cycle as the clear keeps it set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_pending <= 1'b0;
      end else if (irq_edge) begin
         irq_pending <= 1'b1;
      end else if (state == TAKE) begin
         irq_pending <= 1'b0;
      end
   end

   // Interrupt counter: one increment per TAKE cycle, wrapping naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 16'h0000;
      end else if (state == TAKE) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign int_count = count_q;

   // State register; reset drops any in-flight entry/return sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: boundaries are only honoured in RUN, and mret wins
   // over a pending interrupt so the interrupt is re-evaluated next boundary.
   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (instr_done) begin
               if (is_mret) begin
                  state_next = RET;
               end else if (irq_pending && mie && mstatus) begin
                  state_next = TAKE;
               end
            end
         end
         TAKE:    state_next = SETTLE;
         RET:     state_next = SETTLE;
         SETTLE:  state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Output decode: pulses and redirect target come straight from the state,
   // and fetch is held in every state other than RUN.
   always_comb begin
      int_taken   = 1'b0;
      int_ret     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0000_0000;
      hold        = 1'b1;
      case (state)
         RUN: begin
            hold = 1'b0;
         end
         TAKE: begin
            int_taken   = 1'b1;
            redirect    = 1'b1;
            redirect_pc = mtvec;
         end
         RET: begin
            int_ret     = 1'b1;
            redirect    = 1'b1;
            redirect_pc = mepc;
         end
         SETTLE: begin
            hold = 1'b1;
         end
         default: begin
            hold = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed, scoreboard-based bench for trap_ctrl.
// Stimulus pushes the expected redirect response into a queue; a monitor
// pops and compares whenever the DUT raises redirect.

module tb_trap_ctrl;

`ifdef TRAP_CTRL_IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        irq;
   logic        instr_done;
   logic        is_mret;
   logic        mie;
   logic        mstatus;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        int_taken;
   logic        int_ret;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        hold;
   logic        irq_pending;
   logic [15:0] int_count;

   typedef struct packed {
      logic        taken;
      logic        ret;
      logic [31:0] pc;
      logic [15:0] count;
   } exp_t;

   exp_t expQ[$];
   exp_t expItem;

   int checks = 0;
   int errors = 0;

   trap_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .irq         (irq),
      .instr_done  (instr_done),
      .is_mret     (is_mret),
      .mie         (mie),
      .mstatus     (mstatus),
      .mtvec       (mtvec),
      .mepc        (mepc),
      .int_taken   (int_taken),
      .int_ret     (int_ret),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .hold        (hold),
      .irq_pending (irq_pending),
      .int_count   (int_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison point shared by the stimulus thread and the monitor.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs; they are sampled by the next rising edge.
   task automatic applyStimulus(input logic irqV, input logic doneV, input logic mretV);
      irq        = irqV;
      instr_done = doneV;
      is_mret    = mretV;
      cyc();
   endtask

   // Raise irq and wait until it has been latched as pending.
   task automatic raiseIrq();
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (SYNC_LAT) applyStimulus(1'b1, 1'b0, 1'b0);
   endtask

   // Drop irq and let the edge detector pipeline settle low.
   task automatic dropIrq();
      repeat (SYNC_LAT + 1) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic expectRedirect(input logic taken, input logic ret,
                                 input logic [31:0] pc, input logic [15:0] count);
      expItem.taken = taken;
      expItem.ret   = ret;
      expItem.pc    = pc;
      expItem.count = count;
      expQ.push_back(expItem);
   endtask

   // Walk from TAKE/RET through SETTLE back to RUN.
   task automatic finishSeq();
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   // Boundary with pending set, arranged so a fresh irq edge lands on the
   // clock edge that ends TAKE; returns with the DUT in SETTLE.
   task automatic takeWithNewEdge();
`ifdef TRAP_CTRL_IRQ_SYNC_EN
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
`else
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
`endif
   endtask

   // Monitor: on every redirect pop the scoreboard; otherwise no pulses and
   // redirect_pc must read 0.
   always @(negedge clk) begin
      if (!rst) begin
         if (redirect) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_redirect actual=1 required=0 pc=0x%0h", redirect_pc);
            end else begin
               expItem = expQ.pop_front();
               checkOutput("mon_int_taken", {31'd0, int_taken}, {31'd0, expItem.taken});
               checkOutput("mon_int_ret", {31'd0, int_ret}, {31'd0, expItem.ret});
               checkOutput("mon_redirect_pc", redirect_pc, expItem.pc);
               checkOutput("mon_int_count", {16'd0, int_count}, {16'd0, expItem.count});
            end
         end else begin
            checkOutput("mon_idle_pulses", {30'd0, int_taken, int_ret}, 32'd0);
            checkOutput("mon_idle_pc", redirect_pc, 32'd0);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      rst        = 1'b1;
      irq        = 1'b0;
      instr_done = 1'b0;
      is_mret    = 1'b0;
      mie        = 1'b1;
      mstatus    = 1'b1;
      mtvec      = 32'h0000_0100;
      mepc       = 32'h0000_002C;
      #2;
      checkOutput("rst_int_taken", {31'd0, int_taken}, 32'd0);
      checkOutput("rst_int_ret", {31'd0, int_ret}, 32'd0);
      checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
      checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
      checkOutput("rst_hold", {31'd0, hold}, 32'd0);
      checkOutput("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
      checkOutput("rst_int_count", {16'd0, int_count}, 32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      cyc();

      $display("[TB] irq latency, sync stages=%0d", SYNC_LAT);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("lat_edge_k", {31'd0, irq_pending}, {31'd0, (SYNC_LAT == 0)});
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("lat_edge_k1", {31'd0, irq_pending}, {31'd0, (SYNC_LAT == 0)});
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("lat_edge_k2", {31'd0, irq_pending}, 32'd1);
      dropIrq();
      checkOutput("pend_hold_low", {31'd0, irq_pending}, 32'd1);

      $display("[TB] basic take");
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("take_hold", {31'd0, hold}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("settle_hold", {31'd0, hold}, 32'd1);
      checkOutput("settle_pending", {31'd0, irq_pending}, 32'd0);
      checkOutput("settle_count", {16'd0, int_count}, 32'd1);
      checkOutput("settle_redirect", {31'd0, redirect}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("run_hold", {31'd0, hold}, 32'd0);

      $display("[TB] mret");
      expectRedirect(1'b0, 1'b1, 32'h2C, 16'd1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("ret_hold", {31'd0, hold}, 32'd1);
      finishSeq();
      checkOutput("ret_count", {16'd0, int_count}, 32'd1);
      checkOutput("ret_run_hold", {31'd0, hold}, 32'd0);

      $display("[TB] masked");
      mstatus = 1'b0;
      raiseIrq();
      dropIrq();
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("mstatus_mask_hold", {31'd0, hold}, 32'd0);
      checkOutput("mstatus_mask_pending", {31'd0, irq_pending}, 32'd1);
      mstatus = 1'b1;
      mie     = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("mie_mask_hold", {31'd0, hold}, 32'd0);
      mie = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      finishSeq();
      checkOutput("masked_count", {16'd0, int_count}, 32'd2);
      checkOutput("masked_pending", {31'd0, irq_pending}, 32'd0);

      $display("[TB] mret priority and ignored boundaries");
      raiseIrq();
      dropIrq();
      expectRedirect(1'b0, 1'b1, 32'h2C, 16'd2);
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("prio_hold", {31'd0, hold}, 32'd0);
      checkOutput("prio_pending", {31'd0, irq_pending}, 32'd1);
      checkOutput("prio_count", {16'd0, int_count}, 32'd2);
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd2);
      applyStimulus(1'b0, 1'b1, 1'b0);
      finishSeq();
      checkOutput("prio_take_count", {16'd0, int_count}, 32'd3);
      checkOutput("prio_take_pending", {31'd0, irq_pending}, 32'd0);

      $display("[TB] new edge during TAKE");
      raiseIrq();
      dropIrq();
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd3);
      takeWithNewEdge();
      checkOutput("edge_take_pending", {31'd0, irq_pending}, 32'd1);
      checkOutput("edge_take_count", {16'd0, int_count}, 32'd4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd4);
      applyStimulus(1'b1, 1'b1, 1'b0);
      finishSeq();
      checkOutput("edge_second_count", {16'd0, int_count}, 32'd5);
      checkOutput("edge_second_pending", {31'd0, irq_pending}, 32'd0);
      dropIrq();

      $display("[TB] counter wrap");
      force dut.count_q = 16'hFFFE;
      cyc();
      release dut.count_q;
      cyc();
      checkOutput("preset_count", {16'd0, int_count}, 32'h0000_FFFE);
      raiseIrq();
      dropIrq();
      expectRedirect(1'b1, 1'b0, 32'h100, 16'hFFFE);
      applyStimulus(1'b0, 1'b1, 1'b0);
      finishSeq();
      checkOutput("count_ffff", {16'd0, int_count}, 32'h0000_FFFF);
      raiseIrq();
      dropIrq();
      expectRedirect(1'b1, 1'b0, 32'h100, 16'hFFFF);
      applyStimulus(1'b0, 1'b1, 1'b0);
      finishSeq();
      checkOutput("count_wrap", {16'd0, int_count}, 32'd0);

      $display("[TB] reset in SETTLE");
      raiseIrq();
      dropIrq();
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd0);
      takeWithNewEdge();
      checkOutput("pre_rst_hold", {31'd0, hold}, 32'd1);
      rst = 1'b1;
      irq = 1'b0;
      #1;
      checkOutput("rst_settle_hold", {31'd0, hold}, 32'd0);
      checkOutput("rst_settle_pending", {31'd0, irq_pending}, 32'd0);
      checkOutput("rst_settle_count", {16'd0, int_count}, 32'd0);
      checkOutput("rst_settle_redirect", {31'd0, redirect}, 32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_hold", {31'd0, hold}, 32'd0);
      checkOutput("post_rst_pending", {31'd0, irq_pending}, 32'd0);
      raiseIrq();
      dropIrq();
      expectRedirect(1'b1, 1'b0, 32'h100, 16'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      finishSeq();
      checkOutput("post_rst_count", {16'd0, int_count}, 32'd1);

      $display("[TB] reset in TAKE");
      raiseIrq();
      dropIrq();
      applyStimulus(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("rst_take_redirect", {31'd0, redirect}, 32'd0);
      checkOutput("rst_take_int_taken", {31'd0, int_taken}, 32'd0);
      checkOutput("rst_take_pc", redirect_pc, 32'd0);
      checkOutput("rst_take_hold", {31'd0, hold}, 32'd0);
      checkOutput("rst_take_count", {16'd0, int_count}, 32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_rst_take_hold", {31'd0, hold}, 32'd0);
      checkOutput("post_rst_take_count", {16'd0, int_count}, 32'd0);

      checkOutput("queue_empty", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
